// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared widths, access-size and FSM encodings, and the
// fixed-field payload layouts of the EX->MEM and MEM->WB buses.
// The opaque pass-through field (PASS_W bits) sits above the fixed fields
// on both buses.
package mem_stage_pkg;

  localparam int unsigned PASS_W_DEF  = 256;
  localparam int unsigned EX_FIELDS_W = 171;
  localparam int unsigned WB_FIELDS_W = 102;

  function automatic int unsigned ex_to_mem_width(input int unsigned pass_w);
    return pass_w + EX_FIELDS_W;
  endfunction

  function automatic int unsigned mem_to_wb_width(input int unsigned pass_w);
    return pass_w + WB_FIELDS_W;
  endfunction

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10,
    SIZE_D = 2'b11
  } mem_size_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_DONE   = 3'd3,
    ST_CANCEL = 3'd4
  } mem_state_e;

  // Fixed part of the EX->MEM bus, MSB first.
  typedef struct packed {
    logic [31:0] pc;
    logic        reg_wen;
    logic [4:0]  rd;
    logic [63:0] alu_result;
    logic [63:0] store_data;
    logic        mem_read;
    logic        mem_write;
    mem_size_e   mem_size;
    logic        mem_unsigned;
  } ex_fields_t;

  // Fixed part of the MEM->WB bus, MSB first.
  typedef struct packed {
    logic [31:0] pc;
    logic        reg_wen;
    logic [4:0]  rd;
    logic [63:0] reg_wdata;
  } wb_fields_t;

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: all handshake and bus signals around the MEM stage.
//   EX side : ex_to_mem_valid, ex_to_mem_bus -> MEM ; mem_allowin <- MEM
//   WB side : mem_to_wb_valid, mem_to_wb_bus <- MEM ; wb_allowin -> MEM
//   control : mem_flush -> MEM
//   memory  : data_req_* <- MEM ; data_req_ready, data_resp_* -> MEM
//   hazard  : mem_fwd_valid, mem_fwd_rd <- MEM
// master = the MEM stage, slave = its environment.
interface mem_stage_if #(
  parameter int unsigned PASS_W = mem_stage_pkg::PASS_W_DEF
);
  import mem_stage_pkg::*;

  localparam int unsigned EX_W = ex_to_mem_width(PASS_W);
  localparam int unsigned WB_W = mem_to_wb_width(PASS_W);

  logic            ex_to_mem_valid;
  logic            mem_allowin;
  logic [EX_W-1:0] ex_to_mem_bus;
  logic            mem_to_wb_valid;
  logic            wb_allowin;
  logic [WB_W-1:0] mem_to_wb_bus;
  logic            mem_flush;
  logic            data_req_valid;
  logic            data_req_ready;
  logic            data_req_we;
  logic [63:0]     data_req_addr;
  logic [63:0]     data_req_wdata;
  logic [7:0]      data_req_wstrb;
  logic            data_resp_valid;
  logic [63:0]     data_resp_rdata;
  logic            mem_fwd_valid;
  logic [4:0]      mem_fwd_rd;

  modport master (
    input  ex_to_mem_valid, ex_to_mem_bus, wb_allowin, mem_flush,
           data_req_ready, data_resp_valid, data_resp_rdata,
    output mem_allowin, mem_to_wb_valid, mem_to_wb_bus,
           data_req_valid, data_req_we, data_req_addr, data_req_wdata,
           data_req_wstrb, mem_fwd_valid, mem_fwd_rd
  );

  modport slave (
    output ex_to_mem_valid, ex_to_mem_bus, wb_allowin, mem_flush,
           data_req_ready, data_resp_valid, data_resp_rdata,
    input  mem_allowin, mem_to_wb_valid, mem_to_wb_bus,
           data_req_valid, data_req_we, data_req_addr, data_req_wdata,
           data_req_wstrb, mem_fwd_valid, mem_fwd_rd
  );

endinterface

// File: rtl/mem_stage_load_align.sv
// mem_load_align: byte-lane steering for the data port (combinational).
//   rdata_i/off_i/size_i/uns_i -> ld_data_o : lane-selected, extended load
//   sdata_i/off_i/size_i       -> st_wdata_o, st_wstrb_o : store lanes
// Only naturally aligned accesses are meaningful.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [63:0] rdata_i,
  input  logic [2:0]  off_i,
  input  mem_size_e   size_i,
  input  logic        uns_i,
  input  logic [63:0] sdata_i,
  output logic [63:0] ld_data_o,
  output logic [63:0] st_wdata_o,
  output logic [7:0]  st_wstrb_o
);

  logic [63:0] shifted;
  logic [7:0]  mask;

  // Bring the addressed lane down to bit 0.
  assign shifted = rdata_i >> {off_i, 3'b000};

  // Load extension by access size.
  always_comb begin
    ld_data_o = shifted;
    unique case (size_i)
      SIZE_B:  ld_data_o = uns_i ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
      SIZE_H:  ld_data_o = uns_i ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      SIZE_W:  ld_data_o = uns_i ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      SIZE_D:  ld_data_o = shifted;
      default: ld_data_o = shifted;
    endcase
  end

  // Store byte-enable template before lane shift.
  always_comb begin
    mask = 8'hFF;
    unique case (size_i)
      SIZE_B:  mask = 8'h01;
      SIZE_H:  mask = 8'h03;
      SIZE_W:  mask = 8'h0F;
      SIZE_D:  mask = 8'hFF;
      default: mask = 8'hFF;
    endcase
  end

  assign st_wdata_o = sdata_i << {off_i, 3'b000};
  assign st_wstrb_o = mask << off_i;

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage. Latches an instruction from EX, issues a
// data-memory request for loads/stores, waits for the response/ack, aligns
// load data and presents the result to WB under valid/allowin handshake.
//   clk, rst : clock, synchronous active-high reset
//   io       : mem_stage_if.master (EX, WB, flush, data port, hazard taps)
module mem_stage #(
  parameter int unsigned PASS_W = mem_stage_pkg::PASS_W_DEF
) (
  input logic       clk,
  input logic       rst,
  mem_stage_if.master io
);
  import mem_stage_pkg::*;

  localparam int unsigned EX_W = ex_to_mem_width(PASS_W);

  mem_state_e        state_q;
  logic              mem_valid_q;
  logic [PASS_W-1:0] pass_q;
  ex_fields_t        ex_q;
  logic [63:0]       reg_wdata_q;

  logic [PASS_W-1:0] pass_in;
  ex_fields_t        ex_in;
  logic              in_is_mem;
  logic              ready_go;
  logic              allowin;
  logic              accept;
  logic              req_valid;
  logic [63:0]       ld_data;
  logic [63:0]       st_wdata;
  logic [7:0]        st_wstrb;

  assign pass_in   = io.ex_to_mem_bus[EX_W-1 -: PASS_W];
  assign ex_in     = ex_fields_t'(io.ex_to_mem_bus[EX_FIELDS_W-1:0]);
  assign in_is_mem = ex_in.mem_read || ex_in.mem_write;

  // CANCEL blocks new entries until the orphaned response drains.
  assign ready_go  = (state_q == ST_DONE);
  assign allowin   = (state_q != ST_CANCEL) && (!mem_valid_q || (ready_go && io.wb_allowin));
  assign accept    = io.ex_to_mem_valid && allowin && !io.mem_flush;
  assign req_valid = (state_q == ST_REQ) && mem_valid_q && !io.mem_flush;

  mem_load_align u_align (
    .rdata_i    (io.data_resp_rdata),
    .off_i      (ex_q.alu_result[2:0]),
    .size_i     (ex_q.mem_size),
    .uns_i      (ex_q.mem_unsigned),
    .sdata_i    (ex_q.store_data),
    .ld_data_o  (ld_data),
    .st_wdata_o (st_wdata),
    .st_wstrb_o (st_wstrb)
  );

  // Stage FSM and payload registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mem_valid_q <= 1'b0;
      pass_q      <= '0;
      ex_q        <= '0;
      reg_wdata_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (io.mem_flush) begin
            state_q     <= ST_IDLE;
            mem_valid_q <= 1'b0;
          end else if (accept) begin
            mem_valid_q <= 1'b1;
            pass_q      <= pass_in;
            ex_q        <= ex_in;
            reg_wdata_q <= ex_in.alu_result;
            state_q     <= in_is_mem ? ST_REQ : ST_DONE;
          end else if ((state_q == ST_DONE) && io.wb_allowin) begin
            state_q     <= ST_IDLE;
            mem_valid_q <= 1'b0;
          end
        end
        ST_REQ: begin
          if (io.mem_flush) begin
            state_q     <= ST_IDLE;
            mem_valid_q <= 1'b0;
          end else if (io.data_req_ready) begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (io.mem_flush) begin
            // A response arriving with the flush has nothing left to drain.
            mem_valid_q <= 1'b0;
            state_q     <= io.data_resp_valid ? ST_IDLE : ST_CANCEL;
          end else if (io.data_resp_valid) begin
            reg_wdata_q <= ex_q.mem_read ? ld_data : ex_q.alu_result;
            state_q     <= ST_DONE;
          end
        end
        ST_CANCEL: begin
          if (io.data_resp_valid) state_q <= ST_IDLE;
        end
        default: begin
          state_q     <= ST_IDLE;
          mem_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign io.mem_allowin     = allowin;
  assign io.mem_to_wb_valid = mem_valid_q && ready_go && !io.mem_flush;
  assign io.mem_to_wb_bus   = {pass_q, ex_q.pc, ex_q.reg_wen, ex_q.rd, reg_wdata_q};

  assign io.data_req_valid  = req_valid;
  assign io.data_req_we     = req_valid && ex_q.mem_write;
  assign io.data_req_addr   = ex_q.alu_result;
  assign io.data_req_wdata  = st_wdata;
  assign io.data_req_wstrb  = req_valid ? st_wstrb : 8'h00;

  assign io.mem_fwd_valid   = mem_valid_q && ex_q.reg_wen;
  assign io.mem_fwd_rd      = ex_q.rd;

endmodule
